// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and state type for the mdu_seq sequencer.
// ALU opcodes must match the main ALU's encoding.
package mdu_pkg;

    localparam int W = 32;

    localparam logic [3:0] A_NOP = 4'b1111;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude capture and result sign correction for signed MULT/DIV.
// Only instantiated when MDU_SIGNED_EN is defined.
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic         sgn_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] mag_a_o,
    output logic [W-1:0] mag_b_o,
    output logic         neg_a_o,
    output logic         neg_b_o,
    input  logic         is_div_i,
    input  logic         neg_a_i,
    input  logic         neg_b_i,
    input  logic [W-1:0] hi_i,
    input  logic [W-1:0] lo_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);

    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_n;
    logic           neg_r;

    assign neg_a_o = sgn_i & a_i[W-1];
    assign neg_b_o = sgn_i & b_i[W-1];
    assign mag_a_o = neg_a_o ? -a_i : a_i;
    assign mag_b_o = neg_b_o ? -b_i : b_i;

    assign prod   = {hi_i, lo_i};
    assign prod_n = -prod;
    assign neg_r  = neg_a_i ^ neg_b_i;

    // Remainder takes the dividend's sign; quotient/product the xor.
    always_comb begin
        hi_o = hi_i;
        lo_o = lo_i;
        if (is_div_i) begin
            hi_o = neg_a_i ? -hi_i : hi_i;
            lo_o = neg_r ? -lo_i : lo_i;
        end else if (neg_r) begin
            {hi_o, lo_o} = prod_n;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULTU/DIVU sequencer stepping the shared ALU once per grant.
// Define MDU_SIGNED_EN to add signed MULT/DIV with a FIX correction cycle.
module mdu_seq
    import mdu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         alu_req,
    input  logic         alu_gnt,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_result
);

    state_e       state_q;
    logic [4:0]   cnt_q;
    logic [W-1:0] acc_hi_q;
    logic [W-1:0] acc_lo_q;
    logic [W-1:0] opnd_q;
    logic         is_div_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    logic         run;
    logic         step;
    logic         r_msb;
    logic [W-1:0] sh_rem;
    logic [W-1:0] sh_quo;
    logic         carry;
    logic         borrow;
    logic [W-1:0] acc_hi_d;
    logic [W-1:0] acc_lo_d;
    logic [W-1:0] cap_a;
    logic [W-1:0] cap_b;

`ifdef MDU_SIGNED_EN
    logic         sgn_q;
    logic         neg_a_q;
    logic         neg_b_q;
    logic         neg_a_d;
    logic         neg_b_d;
    logic [W-1:0] fix_hi;
    logic [W-1:0] fix_lo;

    mdu_sign_fix u_sign_fix (
        .sgn_i    (op[1]),
        .a_i      (src_a),
        .b_i      (src_b),
        .mag_a_o  (cap_a),
        .mag_b_o  (cap_b),
        .neg_a_o  (neg_a_d),
        .neg_b_o  (neg_b_d),
        .is_div_i (is_div_q),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .hi_o     (fix_hi),
        .lo_o     (fix_lo)
    );
`else
    logic unused_op;

    assign unused_op = op[1];
    assign cap_a     = src_a;
    assign cap_b     = src_b;
`endif

    assign run  = (state_q == S_RUN);
    assign step = run & alu_gnt;

    assign {r_msb, sh_rem, sh_quo} = {acc_hi_q, acc_lo_q, 1'b0};

    assign alu_req = run;
    assign alu_op  = !run ? A_NOP : (is_div_q ? A_SUB : A_ADD);
    assign alu_a   = !run ? '0 : (is_div_q ? sh_rem : acc_hi_q);
    assign alu_b   = !run ? '0 :
                     (is_div_q || acc_lo_q[0]) ? opnd_q : '0;

    // Carry/borrow rebuilt from sign bits since the ALU exports only 32 bits.
    assign carry  = (alu_a[W-1] & alu_b[W-1])
                  | ((alu_a[W-1] | alu_b[W-1]) & ~alu_result[W-1]);
    assign borrow = (~alu_a[W-1] & alu_b[W-1])
                  | ((~alu_a[W-1] | alu_b[W-1]) & alu_result[W-1]);

    always_comb begin
        acc_hi_d = {carry, alu_result[W-1:1]};
        acc_lo_d = {alu_result[0], acc_lo_q[W-1:1]};
        if (is_div_q) begin
            if (r_msb | ~borrow) begin
                acc_hi_d = alu_result;
                acc_lo_d = {sh_quo[W-1:1], 1'b1};
            end else begin
                acc_hi_d = sh_rem;
                acc_lo_d = sh_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_SIGNED_EN
            sgn_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q <= op[0];
                        cnt_q    <= '0;
                        acc_hi_q <= '0;
                        acc_lo_q <= op[0] ? cap_a : cap_b;
                        opnd_q   <= op[0] ? cap_b : cap_a;
`ifdef MDU_SIGNED_EN
                        sgn_q    <= op[1];
                        neg_a_q  <= neg_a_d;
                        neg_b_q  <= neg_b_d;
`endif
                        if (op[0] && src_b == '0) begin
                            hi_q    <= src_a;
                            lo_q    <= '1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (step) begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
`ifdef MDU_SIGNED_EN
                            if (sgn_q) begin
                                state_q <= S_FIX;
                            end else begin
                                hi_q    <= acc_hi_d;
                                lo_q    <= acc_lo_d;
                                state_q <= S_DONE;
                            end
`else
                            hi_q    <= acc_hi_d;
                            lo_q    <= acc_lo_d;
                            state_q <= S_DONE;
`endif
                        end
                    end
                end
`ifdef MDU_SIGNED_EN
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer that executes MULTU/DIVU, and optionally MULT/DIV, by driving the shared 32-bit ALU for one add or subtract step per cycle. It keeps the partial product or remainder and the HI/LO result registers locally. It competes with the main pipeline for the ALU through a request/grant handshake and reports completion with a one-cycle done pulse. It sits beside the ALU in the execute stage; the decoder issues `start`, and HI/LO are read by MFHI/MFLO.

## Interface
- `W`, 32: operand width; fixed to the ALU width.
- `A_NOP`, 4'b1111: ALU opcode driven when the block is not stepping.
- `A_ADD`, 4'b0010: ALU add opcode.
- `A_SUB`, 4'b0110: ALU subtract opcode.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request; accepted only in IDLE.
- `op` in 2: operation select; 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- `src_a` in 32: multiplicand or dividend, captured when `start` is accepted.
- `src_b` in 32: multiplier or divisor, captured when `start` is accepted.
- `busy` out 1: high from the cycle after acceptance until `done`, inclusive.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid from this cycle.
- `hi` out 32: HI result (product upper word, or remainder).
- `lo` out 32: LO result (product lower word, or quotient).
- `alu_req` out 1: the block wants the ALU this cycle.
- `alu_gnt` in 1: the ALU is granted to this block this cycle.
- `alu_op` out 4: ALU opcode.
- `alu_a` out 32: ALU operand A.
- `alu_b` out 32: ALU operand B.
- `alu_result` in 32: combinational ALU output for the current cycle.

## Operation
- States:
  - IDLE: on `start`, capture the operands and zero `cnt`; go to RUN, or to DONE if the op is a divide and `src_b`==0.
  - RUN: one step per granted cycle.
  - FIX: signed sign correction; present only with the macro.
  - DONE: 1 cycle, then IDLE.
- Multiply step, shift-add: `alu_op`=A_ADD, `alu_a`=acc_hi, `alu_b`= mcand if mplier[0] else 0.
  - Carry = (a31&b31) | ((a31|b31)&~s31), computed locally.
  - {carry, sum, acc_lo} shifts right by 1 into {acc_hi, acc_lo}.
- Divide step, restoring: shift {rem, quo} left by 1 and remember the bit shifted out as r_msb; `alu_op`=A_SUB, `alu_a`=shifted rem, `alu_b`=divisor.
  - Borrow = (~a31&b31) | ((~a31|b31)&s31).
  - If r_msb or no borrow: rem=result and quo[0]=1. Otherwise rem is kept and quo[0]=0.
- `cnt` increments only on `alu_req&alu_gnt`. RUN exits after step 31; a full operation is 32 granted steps.
- `alu_req`=1 only in RUN. In any other state `alu_op`=A_NOP and `alu_a`/`alu_b`=0.
- `hi`/`lo` load at entry to DONE and hold until the next DONE or `rst`.
  - Multiply: hi=acc_hi, lo=acc_lo.
  - Divide: hi=remainder, lo=quotient.
- Divide by zero: hi=src_a, lo=32'hFFFF_FFFF, with no ALU use.
- `start` while busy is ignored; no queuing.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_req`=0, `alu_op`=A_NOP, `alu_a`=0, `alu_b`=0, state IDLE.
- With `alu_gnt` held high: `start` accepted at cycle 0, RUN for cycles 1–32, `done` at cycle 33.
  - Signed ops with the macro take one extra cycle, so `done` is at cycle 34.
- Divide by zero: `done` at cycle 1.
- Each cycle of `alu_gnt`=0 in RUN stalls all state and delays `done` by one cycle.
- `rst` asserted in any state returns the block to reset values on the next edge; any in-flight operation is lost.
- `start` in the same cycle as `done` is ignored; the earliest accepted restart is the cycle after `done`.

## Configuration
- `MDU_SIGNED_EN` defined:
  - op 10 and 11 capture operand magnitudes using local negate logic and record the result signs.
  - FIX negates the results as needed: product by sign_a^sign_b; quotient by sign_a^sign_b; remainder by sign_a.
- `MDU_SIGNED_EN` undefined:
  - op 10 and 11 execute as MULTU and DIVU respectively.
  - No FIX state and no negate logic.

## Structure
- Shared package `mdu_pkg` holds:
  - ALU opcode constants A_NOP, A_ADD, A_SUB, identical to the ALU's.
  - The `op` encodings.
  - The state enum.
- Natural sub-module: `mdu_sign_fix`, the magnitude and negate logic for operands and results. It is instantiated only under `MDU_SIGNED_EN`.

## Test plan
- MULTU 7×6, gnt=1 -> `done` at cycle 33; hi=0, lo=42; `alu_op`=A_ADD during RUN.
- MULTU 32'hFFFF_FFFF×32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001 (exercises carry).
- DIVU 100/7 -> lo=14, hi=2.
- DIVU 32'hFFFF_FFFF/1 -> lo=32'hFFFF_FFFF, hi=0 (exercises r_msb).
- DIVU 5/0 -> `done` at cycle 1, hi=5, lo=32'hFFFF_FFFF.
- MULTU 3×5 with gnt low for 5 cycles mid-RUN -> `done` at cycle 38, lo=15; `rst` at cycle 10 of a new op -> all outputs 0 at the next edge, no `done`.
- With `MDU_SIGNED_EN`: DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, `done` at cycle 34.
